// File: rtl/accelerator_pkg.sv
// Accelerator-wide shared constants.
package accelerator_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] EMPTY_DATA = '0;

endpackage

// File: rtl/fifo_producer_pkg.sv
// Shared types and helpers for the multi-channel FIFO producer.
package fifo_producer_pkg;

  // Read pipeline depth: issue -> buffer data -> registered FIFO write.
  localparam int unsigned PIPE_DEPTH = 2;

  localparam int unsigned IDLE_B  = 0;
  localparam int unsigned ARB_B   = 1;
  localparam int unsigned BURST_B = 2;
  localparam int unsigned DRAIN_B = 3;
  localparam int unsigned DONE_B  = 4;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ARB   = 5'b00010,
    ST_BURST = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_DONE  = 5'b10000
  } mc_producer_state_t;

  // Words the next burst of a channel will move.
  function automatic int unsigned min_burst(input int unsigned burst_size,
                                            input int unsigned remaining);
    return (remaining < burst_size) ? remaining : burst_size;
  endfunction

endpackage

// File: rtl/single_port_ram_pkg.sv
// Control encodings for the shared single-port buffer interface.
package single_port_ram_pkg;

  localparam logic CS_ENABLE    = 1'b1;
  localparam logic CS_DISABLE   = 1'b0;
  localparam logic OE_ENABLE    = 1'b1;
  localparam logic OE_DISABLE   = 1'b0;
  localparam logic WREQ_ENABLE  = 1'b1;
  localparam logic WREQ_DISABLE = 1'b0;

endpackage

// File: rtl/multi_ch_fifo_producer_rr_arbiter.sv
// Combinational round-robin picker: first eligible channel after i_last.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_elig,
  input  logic [CH_W-1:0]   i_last,
  output logic [NUM_CH-1:0] o_sel_c
);

  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  int unsigned       w_idx;
  logic              w_found;
  logic [NUM_CH-1:0] w_bits;

  // Scan channels in rotating order, starting just after the last served one.
  always_comb begin
    o_sel_c = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_bits  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx  = (32'(i_last) + k) % NUM_CH;
      w_bits = i_elig >> w_idx;
      if (!w_found && w_bits[0]) begin
        w_found = 1'b1;
        o_sel_c = CH_ONE << w_idx;
      end
    end
  end

endmodule

// File: rtl/multi_ch_fifo_producer.sv
// Multi-channel strided buffer reader feeding per-channel FIFOs in credit-gated
// round-robin bursts. Optional performance counters: define PRODUCER_PERF_CNT_EN.
module multi_ch_fifo_producer
  import fifo_producer_pkg::*;
  import single_port_ram_pkg::*;
  import accelerator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned BURST_SIZE  = 4,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned SPACE_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enb,
  output logic                          busy,
  output logic                          done,
  output logic                          request,
  input  logic                          grant,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]  cfg_addr_begin,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]  cfg_addr_step,
  input  logic [NUM_CH*LEN_WIDTH-1:0]   cfg_len,
  input  logic [NUM_CH*SPACE_WIDTH-1:0] fifo_space,
  output logic [NUM_CH-1:0]             fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          to_buffer_cs,
  output logic                          to_buffer_oe,
  output logic [ADDR_WIDTH-1:0]         to_buffer_addr,
  input  logic [DATA_WIDTH-1:0]         to_buffer_R_data,
  output logic                          to_buffer_W_req,
`ifdef PRODUCER_PERF_CNT_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   grant_wait_cycles,
`endif
  output logic [DATA_WIDTH-1:0]         to_buffer_W_data
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BEAT_W = $clog2(BURST_SIZE + 1);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  mc_producer_state_t r_state, w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr [NUM_CH];
  logic [ADDR_WIDTH-1:0] r_step [NUM_CH];
  logic [LEN_WIDTH-1:0]  r_rem  [NUM_CH];
  logic [CH_W-1:0]       r_sel, r_last, r_p1_ch, w_pick;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic                  r_p1_vld;
  logic [ADDR_WIDTH-1:0] r_buf_addr, w_next_addr;
  logic [NUM_CH-1:0]     r_fifo_w_en, w_elig, w_grant_oh;
  logic [DATA_WIDTH-1:0] r_fifo_data;
  logic [LEN_WIDTH-1:0]  w_cur_rem;
  logic                  w_any_rem, w_any_elig, w_issue, w_last_beat, w_pipe_busy;

  // A channel is eligible when it has work and its FIFO can absorb the whole next burst.
  always_comb begin
    w_elig    = '0;
    w_any_rem = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_rem[c] != '0) begin
        w_any_rem = 1'b1;
        if (32'(fifo_space[c*SPACE_WIDTH +: SPACE_WIDTH]) >=
            min_burst(BURST_SIZE, 32'(r_rem[c])))
          w_elig[c] = 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arbiter (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_sel_c (w_grant_oh)
  );

  // One-hot arbiter result to channel index.
  always_comb begin
    w_pick = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_grant_oh[c]) w_pick = CH_W'(c);
    end
  end

  assign w_any_elig  = |w_elig;
  assign w_cur_rem   = r_rem[r_sel];
  assign w_next_addr = r_buf_addr + r_step[r_sel];
  assign w_issue     = r_state[BURST_B] & grant;
  assign w_last_beat = w_issue & ((r_beat_cnt == BEAT_W'(BURST_SIZE - 1)) |
                                  (w_cur_rem == LEN_WIDTH'(1)));
  assign w_pipe_busy = r_p1_vld | (|r_fifo_w_en);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and grant-qualified buffer/arbiter handshake.
  always_comb begin
    w_next_state = r_state;
    request      = 1'b0;
    to_buffer_cs = CS_DISABLE;
    to_buffer_oe = OE_DISABLE;
    unique case (r_state)
      ST_IDLE:  if (enb) w_next_state = ST_ARB;
      ST_ARB: begin
        request = w_any_elig;
        if (!w_any_rem)              w_next_state = ST_DONE;
        else if (w_any_elig && grant) w_next_state = ST_BURST;
      end
      ST_BURST: begin
        request = 1'b1;
        if (grant) begin
          to_buffer_cs = CS_ENABLE;
          to_buffer_oe = OE_ENABLE;
        end
        if (w_last_beat) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: if (!w_pipe_busy) w_next_state = ST_ARB;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Channel contexts, burst bookkeeping and the two-stage read pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_addr[c] <= '0;
        r_step[c] <= '0;
        r_rem[c]  <= '0;
      end
      r_sel       <= '0;
      r_last      <= CH_W'(NUM_CH - 1);
      r_beat_cnt  <= '0;
      r_buf_addr  <= '0;
      r_p1_vld    <= 1'b0;
      r_p1_ch     <= '0;
      r_fifo_w_en <= '0;
      r_fifo_data <= '0;
    end else begin
      if (r_state[IDLE_B] && enb) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_addr[c] <= cfg_addr_begin[c*ADDR_WIDTH +: ADDR_WIDTH];
          r_step[c] <= cfg_addr_step[c*ADDR_WIDTH +: ADDR_WIDTH];
          r_rem[c]  <= cfg_len[c*LEN_WIDTH +: LEN_WIDTH];
        end
        r_last <= CH_W'(NUM_CH - 1);
      end
      if (r_state[ARB_B] && w_any_elig && grant) begin
        r_sel      <= w_pick;
        r_last     <= w_pick;
        r_beat_cnt <= '0;
        r_buf_addr <= r_addr[w_pick];
      end
      if (w_issue) begin
        r_addr[r_sel] <= w_next_addr;
        r_rem[r_sel]  <= w_cur_rem - LEN_WIDTH'(1);
        r_buf_addr    <= w_next_addr;
        r_beat_cnt    <= r_beat_cnt + BEAT_W'(1);
      end
      r_p1_vld    <= w_issue;
      r_p1_ch     <= r_sel;
      r_fifo_w_en <= r_p1_vld ? (CH_ONE << r_p1_ch) : '0;
      if (r_p1_vld) r_fifo_data <= to_buffer_R_data;
    end
  end

`ifdef PRODUCER_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_grant_wait_cycles;

  // Saturating stall and grant-wait counters, cleared at each start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles      <= '0;
      r_grant_wait_cycles <= '0;
    end else if (r_state[IDLE_B] && enb) begin
      r_stall_cycles      <= '0;
      r_grant_wait_cycles <= '0;
    end else begin
      if (r_state[ARB_B] && w_any_rem && !w_any_elig && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'(1);
      if (request && !grant && (r_grant_wait_cycles != '1))
        r_grant_wait_cycles <= r_grant_wait_cycles + 32'(1);
    end
  end

  assign stall_cycles      = r_stall_cycles;
  assign grant_wait_cycles = r_grant_wait_cycles;
`endif

  assign busy             = ~r_state[IDLE_B];
  assign done             = r_state[DONE_B];
  assign to_buffer_addr   = r_buf_addr;
  assign fifo_w_en        = r_fifo_w_en;
  assign fifo_data        = r_fifo_data;
  assign to_buffer_W_req  = WREQ_DISABLE;
  assign to_buffer_W_data = DATA_WIDTH'(EMPTY_DATA);

endmodule

// File: tb/tb_multi_ch_fifo_producer.sv
// Scoreboard bench for multi_ch_fifo_producer (4 channels, default widths).
module tb_multi_ch_fifo_producer;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 16;
  localparam int unsigned LW  = 16;
  localparam int unsigned SW  = 6;

  typedef struct packed {
    logic [NCH-1:0] wen;
    logic [DW-1:0]  data;
  } wr_t;

  logic              clk, rstn, enb, grant;
  logic              busy, done, request;
  logic [NCH*AW-1:0] cfg_addr_begin, cfg_addr_step;
  logic [NCH*LW-1:0] cfg_len;
  logic [NCH*SW-1:0] fifo_space;
  logic [NCH-1:0]    fifo_w_en;
  logic [DW-1:0]     fifo_data, r_data, w_data;
  logic              cs, oe, w_req;
  logic [AW-1:0]     addr;
`ifdef PRODUCER_PERF_CNT_EN
  logic [31:0]       stall_cycles, grant_wait_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  int wr_cnt   = 0;

  logic [AW-1:0] exp_addr_q[$];
  wr_t           exp_wr_q[$];

  multi_ch_fifo_producer dut (
    .clk              (clk),
    .rstn             (rstn),
    .enb              (enb),
    .busy             (busy),
    .done             (done),
    .request          (request),
    .grant            (grant),
    .cfg_addr_begin   (cfg_addr_begin),
    .cfg_addr_step    (cfg_addr_step),
    .cfg_len          (cfg_len),
    .fifo_space       (fifo_space),
    .fifo_w_en        (fifo_w_en),
    .fifo_data        (fifo_data),
    .to_buffer_cs     (cs),
    .to_buffer_oe     (oe),
    .to_buffer_addr   (addr),
    .to_buffer_R_data (r_data),
    .to_buffer_W_req  (w_req),
`ifdef PRODUCER_PERF_CNT_EN
    .stall_cycles     (stall_cycles),
    .grant_wait_cycles(grant_wait_cycles),
`endif
    .to_buffer_W_data (w_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ {a[19:16], 12'h3C5};
  endfunction

  // Buffer model: data one cycle after a selected read.
  always @(posedge clk) begin
    if (cs && oe) r_data <= mem_f(addr);
  end

  // Monitor: pops expected issue addresses and FIFO writes as the DUT presents them.
  always @(negedge clk) begin
    if (rstn) begin
      if (request) req_cnt++;
      if (done) done_cnt++;
      if (cs) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin
          n_errors++;
          $display("FAIL issue_addr: unexpected read at %h, none required", addr);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_addr_q.pop_front();
          if (addr !== ea) begin
            n_errors++;
            $display("FAIL issue_addr: got %h required %h", addr, ea);
          end
        end
      end
      if (fifo_w_en != '0) begin
        wr_cnt++;
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          n_errors++;
          $display("FAIL fifo_write: unexpected wen=%b data=%h, none required", fifo_w_en, fifo_data);
        end else begin
          wr_t ew;
          ew = exp_wr_q.pop_front();
          if (fifo_w_en !== ew.wen || fifo_data !== ew.data) begin
            n_errors++;
            $display("FAIL fifo_write: got wen=%b data=%h required wen=%b data=%h",
                     fifo_w_en, fifo_data, ew.wen, ew.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_cfg();
    cfg_addr_begin = '0;
    cfg_addr_step  = '0;
    cfg_len        = '0;
    fifo_space     = {NCH{6'd63}};
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [LW-1:0] l);
    cfg_addr_begin[ch*AW +: AW] = b;
    cfg_addr_step[ch*AW +: AW]  = s;
    cfg_len[ch*LW +: LW]        = l;
  endtask

  task automatic push_rd(input int ch, input logic [AW-1:0] a);
    wr_t w;
    w.wen  = NCH'(1) << ch;
    w.data = mem_f(a);
    exp_addr_q.push_back(a);
    exp_wr_q.push_back(w);
  endtask

  task automatic start();
    @(negedge clk);
    enb = 1'b1;
    @(posedge clk);
    #1 enb = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   i;
    logic seen;
    i    = 0;
    seen = 1'b0;
    while (!seen && i < 300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      i++;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_done_timeout: got no done in 300 cycles required done=1", name);
    end
  endtask

  task automatic wait_cs(input string name);
    int   i;
    logic seen;
    i    = 0;
    seen = 1'b0;
    while (!seen && i < 50) begin
      @(negedge clk);
      if (cs) seen = 1'b1;
      i++;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_cs_timeout: got no read in 50 cycles required cs=1", name);
    end
  endtask

  task automatic chk_drained(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_addr_q_empty"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, w0;
    rstn  = 1'b0;
    enb   = 1'b0;
    grant = 1'b1;
    clear_cfg();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_request", 32'(request), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_wen", 32'(fifo_w_en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data), 32'd0);
    chk("rst_w_req", 32'(w_req), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Two channels interleaved by round robin
    clear_cfg();
    set_ch(0, 20'h00010, 20'h00001, 16'd6);
    set_ch(1, 20'h00100, 20'hFFFFE, 16'd4);
    for (int i = 0; i < 4; i++) push_rd(0, 20'h00010 + 20'(i));
    push_rd(1, 20'h00100);
    push_rd(1, 20'h000FE);
    push_rd(1, 20'h000FC);
    push_rd(1, 20'h000FA);
    push_rd(0, 20'h00014);
    push_rd(0, 20'h00015);
    d0 = done_cnt;
    start();
    wait_done("t1");
    chk_drained("t1");
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Credit stall then release
    clear_cfg();
    set_ch(0, 20'h00040, 20'h00001, 16'd3);
    fifo_space[0 +: SW] = 6'd2;
    for (int i = 0; i < 3; i++) push_rd(0, 20'h00040 + 20'(i));
    r0 = req_cnt;
    w0 = wr_cnt;
    start();
    repeat (10) @(negedge clk);
    chk("t2_stall_request", 32'(request), 32'd0);
    chk("t2_stall_busy", 32'(busy), 32'd1);
    chk("t2_stall_no_req", 32'(req_cnt - r0), 32'd0);
    chk("t2_stall_no_write", 32'(wr_cnt - w0), 32'd0);
    fifo_space[0 +: SW] = 6'd3;
    wait_done("t2");
    chk_drained("t2");
    chk("t2_writes", 32'(wr_cnt - w0), 32'd3);

    // Grant dropped for three cycles during beat 2
    clear_cfg();
    set_ch(0, 20'h00200, 20'h00001, 16'd4);
    for (int i = 0; i < 4; i++) push_rd(0, 20'h00200 + 20'(i));
    start();
    wait_cs("t3");
    @(posedge clk);
    #1 grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_gap_cs", 32'(cs), 32'd0);
      chk("t3_gap_oe", 32'(oe), 32'd0);
      chk("t3_gap_addr", 32'(addr), 32'h00201);
      chk("t3_gap_request", 32'(request), 32'd1);
    end
    @(posedge clk);
    #1 grant = 1'b1;
    wait_done("t3");
    chk_drained("t3");

    // All lengths zero
    clear_cfg();
    r0 = req_cnt;
    w0 = wr_cnt;
    start();
    @(negedge clk);
    chk("t4_c1_done", 32'(done), 32'd0);
    chk("t4_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t4_c2_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t4_c3_done", 32'(done), 32'd0);
    chk("t4_c3_busy", 32'(busy), 32'd0);
    chk("t4_no_request", 32'(req_cnt - r0), 32'd0);
    chk("t4_no_write", 32'(wr_cnt - w0), 32'd0);

    // Reset mid-burst, then restart from the configured begin address
    clear_cfg();
    set_ch(0, 20'h00300, 20'h00001, 16'd8);
    exp_addr_q.push_back(20'h00300);
    start();
    wait_cs("t5");
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_cs", 32'(cs), 32'd0);
    chk("t5_rst_oe", 32'(oe), 32'd0);
    chk("t5_rst_request", 32'(request), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_wen", 32'(fifo_w_en), 32'd0);
    chk("t5_rst_addr", 32'(addr), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk_drained("t5_abort");
    set_ch(0, 20'h00300, 20'h00001, 16'd3);
    for (int i = 0; i < 3; i++) push_rd(0, 20'h00300 + 20'(i));
    start();
    wait_done("t5");
    chk_drained("t5");

    // Downward wrap past zero
    clear_cfg();
    set_ch(0, 20'h00001, 20'hFFFFF, 16'd3);
    push_rd(0, 20'h00001);
    push_rd(0, 20'h00000);
    push_rd(0, 20'hFFFFF);
    start();
    wait_done("t6");
    chk_drained("t6");

    // Lone channel served back-to-back, wrapping past the top address
    clear_cfg();
    set_ch(2, 20'hFFFFE, 20'h00001, 16'd6);
    push_rd(2, 20'hFFFFE);
    push_rd(2, 20'hFFFFF);
    for (int i = 0; i < 4; i++) push_rd(2, 20'(i));
    d0 = done_cnt;
    start();
    wait_done("t7");
    chk_drained("t7");
    chk("t7_done_pulses", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
